uart_cmd_decoder: RTL and testbench



---
 rtl/uart_cmd_decoder_if.sv | 29 ++
 rtl/uart_cmd_decoder.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_decoder_if.sv
// UART byte-stream handshake between the Duplex UART and the command decoder.
// The master side is the UART (receiver and transmitter); the slave side is
// the decoder, which consumes received bytes and produces reply bytes.
interface uart_cmd_decoder_if;
    logic       rx_done_flag;
    logic [7:0] data_received;
    logic       rx_error_flag;
    logic       tx_done_flag;
    logic [7:0] tx_data;
    logic       tx_send;

    modport master (
        output rx_done_flag,
        output data_received,
        output rx_error_flag,
        output tx_done_flag,
        input  tx_data,
        input  tx_send
    );

    modport slave (
        input  rx_done_flag,
        input  data_received,
        input  rx_error_flag,
        input  tx_done_flag,
        output tx_data,
        output tx_send
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// UART command decoder.
// Assembles 4-byte frames {SOF, OPCODE, ARG, CHK} with CHK = OPCODE ^ ARG,
// executes LED and temperature-setpoint commands, and answers each frame
// with a single reply byte (ACK, NAK or the setpoint value).
// Optional build macro UART_CMD_TIMEOUT_EN adds an inter-byte timeout that
// abandons a partial frame after TIMEOUT_CYCLES idle clocks.
module uart_cmd_decoder #(
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
    parameter logic [7:0]  SETPOINT_INIT  = 8'd4
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_cmd_decoder_if.slave        uart,
    output logic                     led_o,
    output logic [7:0]               setpoint_o,
    output logic                     busy_o,
    output logic [7:0]               err_count_o
);

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam logic [7:0] OP_LED_TOGGLE = 8'h01;
    localparam logic [7:0] OP_LED_SET    = 8'h02;
    localparam logic [7:0] OP_SP_WRITE   = 8'h03;
    localparam logic [7:0] OP_SP_READ    = 8'h04;
    localparam logic [7:0] OP_ERR_CLEAR  = 8'h05;

    typedef enum logic [2:0] {
        IDLE,
        GET_OP,
        GET_ARG,
        GET_CHK,
        EXEC,
        WAIT_TX
    } state_t;

    state_t     state_q, state_d;

    logic       rxPrev_q;
    logic       txPrev_q;
    logic       rxEvent;
    logic       txEvent;
    logic       sofAccepted;
    logic       inFrame;
    logic       timeoutHit;

    logic [7:0] opcode_q, opcode_d;
    logic [7:0] arg_q, arg_d;
    logic [7:0] chk_q, chk_d;
    logic       frameBad_q, frameBad_d;
    logic [7:0] txData_q, txData_d;
    logic       txSend_q, txSend_d;
    logic       led_q, led_d;
    logic [7:0] setpoint_q, setpoint_d;
    logic [7:0] errCount_q, errCount_d;

    logic       chkOk;
    logic       cmdOk;
    logic       errInc;
    logic       errClear;
    logic [7:0] reply;

    // Remember last level of both done flags so a held-high flag is one event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxPrev_q <= 1'b0;
            txPrev_q <= 1'b0;
        end else begin
            rxPrev_q <= uart.rx_done_flag;
            txPrev_q <= uart.tx_done_flag;
        end
    end

    assign rxEvent     = uart.rx_done_flag & ~rxPrev_q;
    assign txEvent     = uart.tx_done_flag & ~txPrev_q;
    assign sofAccepted = rxEvent && (uart.data_received == SOF_BYTE) && !uart.rx_error_flag;
    assign inFrame     = (state_q == GET_OP) || (state_q == GET_ARG) || (state_q == GET_CHK);

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;

    // A received byte always wins over a timeout landing in the same cycle
    assign timeoutHit = inFrame && !rxEvent && (timeoutCnt_q == TIMEOUT_LAST);

    // Count idle clocks between frame bytes; parked at zero outside a frame
    always_comb begin
        timeoutCnt_d = '0;
        if (inFrame && !rxEvent && !timeoutHit) begin
            timeoutCnt_d = timeoutCnt_q + 1'b1;
        end
    end

    // Inter-byte timeout counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeoutCnt_q <= '0;
        end else begin
            timeoutCnt_q <= timeoutCnt_d;
        end
    end
`else
    // Without the timeout a partial frame simply waits for its remaining bytes;
    // the parameter is still accepted so both builds share one instantiation.
    localparam int unsigned unusedTimeoutCycles = TIMEOUT_CYCLES;

    assign timeoutHit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: walk the frame one rx event per byte, then reply and wait
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sofAccepted) begin
                    state_d = GET_OP;
                end
            end
            GET_OP: begin
                if (timeoutHit) begin
                    state_d = IDLE;
                end else if (rxEvent) begin
                    state_d = GET_ARG;
                end
            end
            GET_ARG: begin
                if (timeoutHit) begin
                    state_d = IDLE;
                end else if (rxEvent) begin
                    state_d = GET_CHK;
                end
            end
            GET_CHK: begin
                if (timeoutHit) begin
                    state_d = IDLE;
                end else if (rxEvent) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (txEvent) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign chkOk = (chk_q == (opcode_q ^ arg_q));

    // FSM outputs: latch frame bytes, execute the command and stage the reply
    always_comb begin
        opcode_d   = opcode_q;
        arg_d      = arg_q;
        chk_d      = chk_q;
        frameBad_d = frameBad_q;
        txData_d   = txData_q;
        txSend_d   = 1'b0;
        led_d      = led_q;
        setpoint_d = setpoint_q;
        cmdOk      = 1'b0;
        errInc     = 1'b0;
        errClear   = 1'b0;
        reply      = NAK_BYTE;

        unique case (state_q)
            IDLE: begin
                if (sofAccepted) begin
                    frameBad_d = 1'b0;
                end
            end
            GET_OP: begin
                if (rxEvent && !timeoutHit) begin
                    opcode_d = uart.data_received;
                    if (uart.rx_error_flag) begin
                        frameBad_d = 1'b1;
                    end
                end
                errInc = timeoutHit;
            end
            GET_ARG: begin
                if (rxEvent && !timeoutHit) begin
                    arg_d = uart.data_received;
                    if (uart.rx_error_flag) begin
                        frameBad_d = 1'b1;
                    end
                end
                errInc = timeoutHit;
            end
            GET_CHK: begin
                if (rxEvent && !timeoutHit) begin
                    chk_d = uart.data_received;
                    if (uart.rx_error_flag) begin
                        frameBad_d = 1'b1;
                    end
                end
                errInc = timeoutHit;
            end
            EXEC: begin
                if (!frameBad_q && chkOk) begin
                    unique case (opcode_q)
                        OP_LED_TOGGLE: begin
                            led_d = ~led_q;
                            reply = ACK_BYTE;
                            cmdOk = 1'b1;
                        end
                        OP_LED_SET: begin
                            led_d = arg_q[0];
                            reply = ACK_BYTE;
                            cmdOk = 1'b1;
                        end
                        OP_SP_WRITE: begin
                            setpoint_d = arg_q;
                            reply      = ACK_BYTE;
                            cmdOk      = 1'b1;
                        end
                        OP_SP_READ: begin
                            reply = setpoint_q;
                            cmdOk = 1'b1;
                        end
                        OP_ERR_CLEAR: begin
                            errClear = 1'b1;
                            reply    = ACK_BYTE;
                            cmdOk    = 1'b1;
                        end
                        default: begin
                            cmdOk = 1'b0;
                        end
                    endcase
                end
                errInc   = !cmdOk;
                txData_d = reply;
                txSend_d = 1'b1;
            end
            WAIT_TX: begin
                txSend_d = 1'b0;
            end
            default: begin
                txSend_d = 1'b0;
            end
        endcase

        errCount_d = errCount_q;
        if (errInc && (errCount_q != 8'hFF)) begin
            errCount_d = errCount_q + 8'd1;
        end
        if (errClear) begin
            errCount_d = 8'd0;
        end
    end

    // Datapath registers: frame bytes, reply, LED, setpoint and error counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q   <= 8'd0;
            arg_q      <= 8'd0;
            chk_q      <= 8'd0;
            frameBad_q <= 1'b0;
            txData_q   <= 8'd0;
            txSend_q   <= 1'b0;
            led_q      <= 1'b0;
            setpoint_q <= SETPOINT_INIT;
            errCount_q <= 8'd0;
        end else begin
            opcode_q   <= opcode_d;
            arg_q      <= arg_d;
            chk_q      <= chk_d;
            frameBad_q <= frameBad_d;
            txData_q   <= txData_d;
            txSend_q   <= txSend_d;
            led_q      <= led_d;
            setpoint_q <= setpoint_d;
            errCount_q <= errCount_d;
        end
    end

    assign uart.tx_data = txData_q;
    assign uart.tx_send = txSend_q;
    assign led_o        = led_q;
    assign setpoint_o   = setpoint_q;
    assign err_count_o  = errCount_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder.
// Drives UART byte events through the interface; expected reply bytes are
// queued as frames are sent and checked by an independent reply monitor.
module tb_uart_cmd_decoder;

    logic       clk;
    logic       reset;
    logic       led;
    logic [7:0] setpoint;
    logic       busy;
    logic [7:0] errCount;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cycleCnt    = 0;
    int         lastRaise   = 0;
    int         txDelay     = 8;
    logic [7:0] expQ[$];

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(
        .SOF_BYTE       (8'hA5),
        .TIMEOUT_CYCLES (100),
        .SETPOINT_INIT  (8'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart        (bus),
        .led_o       (led),
        .setpoint_o  (setpoint),
        .busy_o      (busy),
        .err_count_o (errCount)
    );

    // Free-running clock and a cycle counter for latency measurement
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cycleCnt = cycleCnt + 1;
    end

    // Hard stop in case the bench itself loses its way
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One received byte: flag high for 'hold' clocks, then low for 'gap' clocks
    task automatic applyStimulus(input logic [7:0] data, input bit rxErr, input int hold, input int gap);
        @(negedge clk);
        bus.data_received = data;
        bus.rx_error_flag = rxErr;
        bus.rx_done_flag  = 1'b1;
        lastRaise         = cycleCnt;
        repeat (hold) @(negedge clk);
        bus.rx_done_flag  = 1'b0;
        bus.rx_error_flag = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] chk,
                             input bit errOnArg, input int hold);
        applyStimulus(8'hA5, 1'b0, hold, 1);
        applyStimulus(op, 1'b0, hold, 1);
        applyStimulus(arg, errOnArg, hold, 1);
        applyStimulus(chk, 1'b0, hold, 1);
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((busy || (expQ.size() != 0) || bus.tx_done_flag) && (n < 400)) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput({name, "_idle_timeout"}, 32'(n < 400), 32'd1);
    endtask

    // Reply monitor: every tx_send pulse must match the next queued reply
    always @(negedge clk) begin
        if (bus.tx_send === 1'b1) begin
            if (expQ.size() == 0) begin
                vectors     = vectors + 1;
                miscompares = miscompares + 1;
                $display("[TB] FAIL unexpected_tx_send: got tx_data %0h, expected no reply", bus.tx_data);
            end else begin
                checkOutput("reply_byte", bus.tx_data, expQ.pop_front());
                checkOutput("reply_latency", cycleCnt, lastRaise + 2);
            end
        end
    end

    // Transmitter model: reports the end of each reply byte after txDelay clocks
    initial begin
        bus.tx_done_flag = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_send === 1'b1) begin
                repeat (txDelay) @(negedge clk);
                bus.tx_done_flag = 1'b1;
                repeat (2) @(negedge clk);
                bus.tx_done_flag = 1'b0;
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_tx_data"}, bus.tx_data, 8'h00);
        checkOutput({tag, "_tx_send"}, bus.tx_send, 1'b0);
        checkOutput({tag, "_led"}, led, 1'b0);
        checkOutput({tag, "_setpoint"}, setpoint, 8'h04);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_err_count"}, errCount, 8'h00);
    endtask

    initial begin
        bus.rx_done_flag  = 1'b0;
        bus.data_received = 8'h00;
        bus.rx_error_flag = 1'b0;
        reset             = 1'b1;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;
        @(negedge clk);

        // Setpoint readback straight after reset
        expQ.push_back(8'h04);
        sendFrame(8'h04, 8'h00, 8'h04, 1'b0, 1);
        waitIdle("read_init");

        // Two LED toggles
        expQ.push_back(8'h06);
        sendFrame(8'h01, 8'h00, 8'h01, 1'b0, 1);
        waitIdle("toggle1");
        checkOutput("led_after_toggle1", led, 1'b1);
        expQ.push_back(8'h06);
        sendFrame(8'h01, 8'h00, 8'h01, 1'b0, 1);
        waitIdle("toggle2");
        checkOutput("led_after_toggle2", led, 1'b0);

        // Setpoint write then read back
        expQ.push_back(8'h06);
        sendFrame(8'h03, 8'hF8, 8'hFB, 1'b0, 1);
        checkOutput("busy_during_reply", busy, 1'b1);
        waitIdle("sp_write");
        checkOutput("setpoint_written", setpoint, 8'hF8);
        checkOutput("busy_after_tx_done", busy, 1'b0);
        expQ.push_back(8'hF8);
        sendFrame(8'h04, 8'h00, 8'h04, 1'b0, 1);
        waitIdle("sp_read");

        // Bad checksum, then error-counter clear
        expQ.push_back(8'h15);
        sendFrame(8'h02, 8'h01, 8'h00, 1'b0, 1);
        waitIdle("bad_chk");
        checkOutput("led_after_bad_chk", led, 1'b0);
        checkOutput("err_after_bad_chk", errCount, 8'd1);
        expQ.push_back(8'h06);
        sendFrame(8'h05, 8'h00, 8'h05, 1'b0, 1);
        waitIdle("err_clear");
        checkOutput("err_after_clear", errCount, 8'd0);

        // Unknown opcode and a receive error on the ARG byte
        expQ.push_back(8'h15);
        sendFrame(8'h07, 8'h00, 8'h07, 1'b0, 1);
        waitIdle("bad_opcode");
        checkOutput("err_after_bad_opcode", errCount, 8'd1);
        expQ.push_back(8'h15);
        sendFrame(8'h02, 8'h01, 8'h03, 1'b1, 1);
        waitIdle("rx_error");
        checkOutput("led_after_rx_error", led, 1'b0);
        checkOutput("err_after_rx_error", errCount, 8'd2);

        // Non-SOF byte and an errored SOF in IDLE must not start a frame
        applyStimulus(8'h33, 1'b0, 1, 1);
        checkOutput("busy_after_non_sof", busy, 1'b0);
        applyStimulus(8'hA5, 1'b1, 1, 1);
        checkOutput("busy_after_bad_sof", busy, 1'b0);

        // Held-high rx flag counts once; SOF during WAIT_TX is dropped
        txDelay = 40;
        expQ.push_back(8'h06);
        sendFrame(8'h02, 8'h01, 8'h03, 1'b0, 10);
        applyStimulus(8'hA5, 1'b0, 1, 1);
        checkOutput("busy_in_wait_tx", busy, 1'b1);
        waitIdle("held_flag");
        checkOutput("led_after_held_frame", led, 1'b1);
        applyStimulus(8'h01, 1'b0, 1, 1);
        applyStimulus(8'h00, 1'b0, 1, 1);
        applyStimulus(8'h01, 1'b0, 1, 1);
        repeat (10) @(negedge clk);
        checkOutput("led_after_orphan_bytes", led, 1'b1);
        checkOutput("busy_after_orphan_bytes", busy, 1'b0);
        checkOutput("err_after_orphan_bytes", errCount, 8'd2);
        txDelay = 8;

        // Error counter saturates at 255, clear still wins
        txDelay = 2;
        for (int i = 0; i < 256; i++) begin
            expQ.push_back(8'h15);
            sendFrame(8'h02, 8'h01, 8'h00, 1'b0, 1);
            waitIdle("saturate");
        end
        checkOutput("err_saturated", errCount, 8'hFF);
        expQ.push_back(8'h06);
        sendFrame(8'h05, 8'h00, 8'h05, 1'b0, 1);
        waitIdle("clear_saturated");
        checkOutput("err_after_sat_clear", errCount, 8'd0);
        txDelay = 8;

`ifdef UART_CMD_TIMEOUT_EN
        // Partial frame abandoned after 100 idle clocks, no reply
        applyStimulus(8'hA5, 1'b0, 1, 1);
        applyStimulus(8'h03, 1'b0, 1, 1);
        repeat (90) @(negedge clk);
        checkOutput("busy_before_timeout", busy, 1'b1);
        repeat (20) @(negedge clk);
        checkOutput("busy_after_timeout", busy, 1'b0);
        checkOutput("err_after_timeout", errCount, 8'd1);
        checkOutput("setpoint_after_timeout", setpoint, 8'hF8);
        expQ.push_back(8'hF8);
        sendFrame(8'h04, 8'h00, 8'h04, 1'b0, 1);
        waitIdle("after_timeout");
`else
        // Partial frame waits indefinitely, then completes normally
        applyStimulus(8'hA5, 1'b0, 1, 1);
        applyStimulus(8'h03, 1'b0, 1, 1);
        repeat (150) @(negedge clk);
        checkOutput("busy_partial_frame", busy, 1'b1);
        expQ.push_back(8'h06);
        applyStimulus(8'h10, 1'b0, 1, 1);
        applyStimulus(8'h13, 1'b0, 1, 1);
        waitIdle("late_bytes");
        checkOutput("setpoint_late_frame", setpoint, 8'h10);
`endif

        // Reset while waiting for tx_done clears everything at once
        txDelay = 30;
        expQ.push_back(8'h06);
        sendFrame(8'h02, 8'h01, 8'h03, 1'b0, 1);
        repeat (3) @(negedge clk);
        checkOutput("busy_before_reset", busy, 1'b1);
        checkOutput("led_before_reset", led, 1'b1);
        reset = 1'b1;
        #1;
        checkResetValues("async_reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("busy_after_reset_release", busy, 1'b0);
        checkOutput("reply_queue_drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
